// File: rtl/seq_extreme_finder.sv
// seq_extreme_finder: start/done reduction unit. On start it latches a compare
// mode and an element count, accepts that many words over a valid/ready
// stream, and reports the extreme value and the index of its first occurrence.
module seq_extreme_finder #(
    parameter int WIDTH   = 32,
    parameter int MAX_LEN = 16,
    parameter int LEN_W   = $clog2(MAX_LEN + 1),
    parameter int IDX_W   = (MAX_LEN > 1) ? $clog2(MAX_LEN) : 1
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    input  logic [LEN_W-1:0] len,
    input  logic             mode_max,
    input  logic             mode_signed,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] in_data,
    output logic [WIDTH-1:0] result,
    output logic [IDX_W-1:0] result_idx,
    output logic             empty,
    output logic             done
);

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_ACCEPT = 2'd1,
        ST_FINISH = 2'd2
    } state_t;

    // Largest legal element count, expressed at the width of the len port.
    localparam logic [LEN_W-1:0] MAX_LEN_L = LEN_W'(MAX_LEN);

    state_t           state_q, state_d;
    logic [WIDTH-1:0] best_q, best_d;
    logic [IDX_W-1:0] best_idx_q, best_idx_d;
    logic [IDX_W-1:0] count_q, count_d;
    logic [LEN_W-1:0] len_q, len_d;
    logic             max_q, max_d;
    logic             signed_q, signed_d;
    logic [WIDTH-1:0] result_q, result_d;
    logic [IDX_W-1:0] result_idx_q, result_idx_d;
    logic             empty_q, empty_d;
    logic             done_q, done_d;

    logic             greater;
    logic             less;
    logic             better;
    logic             beat;
    logic             last_beat;
    logic [LEN_W-1:0] len_clamped;
    logic [LEN_W-1:0] count_ext;

    // Compare the incoming word against the running best in the latched mode.
    // Comparison only, so the signed extremes cannot overflow.
    always_comb begin
        greater = 1'b0;
        less    = 1'b0;
        if (signed_q) begin
            greater = $signed(in_data) > $signed(best_q);
            less    = $signed(in_data) < $signed(best_q);
        end else begin
            greater = in_data > best_q;
            less    = in_data < best_q;
        end
        // Strict compare: equal values keep the earlier index.
        better = max_q ? greater : less;
    end

    // Stream handshake, length clamp and last-beat detection.
    always_comb begin
        in_ready    = (state_q == ST_ACCEPT);
        beat        = in_valid && in_ready;
        len_clamped = (len > MAX_LEN_L) ? MAX_LEN_L : len;
        count_ext   = LEN_W'(count_q);
        last_beat   = (count_ext == (len_q - LEN_W'(1)));
    end

    // Next-state and datapath updates; everything holds unless changed below.
    always_comb begin
        state_d      = state_q;
        best_d       = best_q;
        best_idx_d   = best_idx_q;
        count_d      = count_q;
        len_d        = len_q;
        max_d        = max_q;
        signed_d     = signed_q;
        result_d     = result_q;
        result_idx_d = result_idx_q;
        empty_d      = empty_q;
        done_d       = done_q;

        case (state_q)
            ST_IDLE: begin
                if (start) begin
                    max_d    = mode_max;
                    signed_d = mode_signed;
                    len_d    = len_clamped;
                    count_d  = '0;
                    done_d   = 1'b0;
                    empty_d  = 1'b0;
                    if (len == '0) begin
                        // Nothing to reduce: answer immediately and stay idle.
                        result_d     = '0;
                        result_idx_d = '0;
                        empty_d      = 1'b1;
                        done_d       = 1'b1;
                    end else begin
                        state_d = ST_ACCEPT;
                    end
                end
            end

            ST_ACCEPT: begin
                if (beat) begin
                    if ((count_q == '0) || better) begin
                        best_d     = in_data;
                        best_idx_d = count_q;
                    end
                    count_d = count_q + IDX_W'(1);
                    if (last_beat) begin
                        state_d = ST_FINISH;
                    end
                end
            end

            ST_FINISH: begin
                result_d     = best_q;
                result_idx_d = best_idx_q;
                done_d       = 1'b1;
                state_d      = ST_IDLE;
            end

            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // State and datapath registers; reset abandons any operation in flight.
    always_ff @(posedge clk) begin
        if (!reset) begin
            state_q      <= ST_IDLE;
            best_q       <= '0;
            best_idx_q   <= '0;
            count_q      <= '0;
            len_q        <= '0;
            max_q        <= 1'b0;
            signed_q     <= 1'b0;
            result_q     <= '0;
            result_idx_q <= '0;
            empty_q      <= 1'b0;
            done_q       <= 1'b0;
        end else begin
            state_q      <= state_d;
            best_q       <= best_d;
            best_idx_q   <= best_idx_d;
            count_q      <= count_d;
            len_q        <= len_d;
            max_q        <= max_d;
            signed_q     <= signed_d;
            result_q     <= result_d;
            result_idx_q <= result_idx_d;
            empty_q      <= empty_d;
            done_q       <= done_d;
        end
    end

    assign result     = result_q;
    assign result_idx = result_idx_q;
    assign empty      = empty_q;
    assign done       = done_q;

endmodule

// File: tb/tb_seq_extreme_finder.sv
// Bench for seq_extreme_finder: directed scenarios plus randomized operations,
// checked every cycle against a transaction-level reference model.
module tb_seq_extreme_finder;

    localparam int W       = 32;
    localparam int MAXL    = 16;
    localparam int LEN_W   = $clog2(MAXL + 1);
    localparam int IDX_W   = $clog2(MAXL);

    logic             clk = 1'b0;
    logic             reset;
    logic             start;
    logic [LEN_W-1:0] len;
    logic             mode_max;
    logic             mode_signed;
    logic             in_valid;
    logic             in_ready;
    logic [W-1:0]     in_data;
    logic [W-1:0]     result;
    logic [IDX_W-1:0] result_idx;
    logic             empty;
    logic             done;

    int tests = 0;
    int fails = 0;
    bit chk_en = 1'b0;

    seq_extreme_finder #(.WIDTH(W), .MAX_LEN(MAXL)) dut (
        .clk        (clk),
        .reset      (reset),
        .start      (start),
        .len        (len),
        .mode_max   (mode_max),
        .mode_signed(mode_signed),
        .in_valid   (in_valid),
        .in_ready   (in_ready),
        .in_data    (in_data),
        .result     (result),
        .result_idx (result_idx),
        .empty      (empty),
        .done       (done)
    );

    always #5 clk = ~clk;

    // ---------------- reference model ----------------
    logic [W-1:0] m_beats[$];
    bit           m_acc = 0;     // operation is taking beats
    bit           m_fin = 0;     // all beats taken, answer due next edge
    int           m_len = 0;
    bit           m_max = 0;
    bit           m_sgn = 0;
    logic [W-1:0] e_res = '0;
    int           e_idx = 0;
    bit           e_done = 0;
    bit           e_empty = 0;

    // Map a word to an unsigned key whose ordering matches the selected compare.
    function automatic logic [W-1:0] order_key(input logic [W-1:0] x, input bit sgn);
        logic [W-1:0] flip;
        flip = '0;
        flip[W-1] = sgn;
        return x ^ flip;
    endfunction

    // Two passes: find the extreme value, then the first position holding it.
    function automatic void extreme(output logic [W-1:0] val, output int idx);
        logic [W-1:0] bk;
        bk  = order_key(m_beats[0], m_sgn);
        val = m_beats[0];
        foreach (m_beats[i]) begin
            if (m_max ? (order_key(m_beats[i], m_sgn) > bk) : (order_key(m_beats[i], m_sgn) < bk)) begin
                bk  = order_key(m_beats[i], m_sgn);
                val = m_beats[i];
            end
        end
        idx = 0;
        for (int i = m_beats.size() - 1; i >= 0; i--)
            if (m_beats[i] == val) idx = i;
    endfunction

    always @(posedge clk) begin
        if (!reset) begin
            m_acc = 0; m_fin = 0; m_beats.delete();
            e_done = 0; e_res = '0; e_idx = 0; e_empty = 0;
        end else if (m_fin) begin
            m_fin = 0;
            extreme(e_res, e_idx);
            e_done = 1;
        end else if (m_acc) begin
            if (in_valid) begin
                m_beats.push_back(in_data);
                if (m_beats.size() == m_len) begin
                    m_acc = 0;
                    m_fin = 1;
                end
            end
        end else if (start) begin
            m_max = mode_max;
            m_sgn = mode_signed;
            m_len = (int'(len) > MAXL) ? MAXL : int'(len);
            m_beats.delete();
            e_empty = 0;
            e_done  = 0;
            if (len == 0) begin
                e_done = 1; e_empty = 1; e_res = '0; e_idx = 0;
            end else begin
                m_acc = 1;
            end
        end
    end

    task automatic cmp(input string name, input logic [63:0] act, input logic [63:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s at %0t: got %0h, expected %0h", name, $time, act, exp);
        end
    endtask

    // Per-cycle compare of every output against the model.
    always @(negedge clk) begin
        if (chk_en) begin
            cmp("in_ready", 64'(in_ready), 64'(m_acc));
            cmp("done", 64'(done), 64'(e_done));
            cmp("empty", 64'(empty), 64'(e_empty));
            cmp("result", 64'(result), 64'(e_res));
            cmp("result_idx", 64'(result_idx), 64'(e_idx));
        end
    end

    // ---------------- stimulus helpers (all run at negedge) ----------------
    task automatic do_start(input int l, input bit mx, input bit sg);
        start = 1'b1; len = LEN_W'(l); mode_max = mx; mode_signed = sg;
        @(negedge clk);
        start = 1'b0;
        $display("[TB] start len=%0d max=%0d signed=%0d", l, mx, sg);
    endtask

    task automatic send_beat(input logic [W-1:0] d, input int gap, input bit poke);
        int k;
        in_valid = 1'b1; in_data = d;
        k = 0;
        while (!in_ready && k < 100) begin
            @(negedge clk);
            k++;
        end
        if (!in_ready) cmp("beat_timeout", 64'(in_ready), 64'd1);
        if (poke) begin
            // Disturb start/len/mode while busy; the block must ignore them.
            start = 1'b1; len = LEN_W'($urandom_range(0, 31));
            mode_max = 1'($urandom); mode_signed = 1'($urandom);
        end
        @(negedge clk);
        in_valid = 1'b0; start = 1'b0;
        $display("[TB] beat data=%08h", d);
        repeat (gap) @(negedge clk);
    endtask

    task automatic wait_done();
        int k;
        k = 0;
        while (!done && k < 50) begin
            @(negedge clk);
            k++;
        end
        cmp("done_timeout", 64'(done), 64'd1);
        $display("[TB] done result=%08h idx=%0d empty=%0d", result, result_idx, empty);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int acc, late_nr, l, n, sel;
        logic [W-1:0] d;
        logic [W-1:0] s1 [4];
        s1[0] = 32'd5; s1[1] = 32'd9; s1[2] = 32'd3; s1[3] = 32'd9;

        reset = 1'b0; start = 1'b0; len = '0; mode_max = 1'b0; mode_signed = 1'b0;
        in_valid = 1'b0; in_data = '0;
        repeat (3) @(negedge clk);
        chk_en = 1'b1;
        cmp("reset_done", 64'(done), 64'd0);
        cmp("reset_result", 64'(result), 64'd0);
        cmp("reset_ready", 64'(in_ready), 64'd0);
        reset = 1'b1;
        @(negedge clk);

        // 1: unsigned max with a tie; done one FINISH cycle after last beat
        do_start(4, 1, 0);
        for (int i = 0; i < 4; i++) send_beat(s1[i], 0, 0);
        cmp("s1_done_finish_cycle", 64'(done), 64'd0);
        @(negedge clk);
        cmp("s1_done_rise", 64'(done), 64'd1);
        cmp("s1_result", 64'(result), 64'd9);
        cmp("s1_idx", 64'(result_idx), 64'd1);

        // 2: signed min with gaps, then the same data unsigned
        do_start(3, 0, 1);
        send_beat(32'h00000001, 3, 0);
        send_beat(32'hFFFFFFFF, 3, 0);
        send_beat(32'h80000000, 3, 0);
        wait_done();
        cmp("s2_smin_result", 64'(result), 64'h80000000);
        cmp("s2_smin_idx", 64'(result_idx), 64'd2);
        do_start(3, 0, 0);
        send_beat(32'h00000001, 0, 0);
        send_beat(32'hFFFFFFFF, 0, 0);
        send_beat(32'h80000000, 0, 0);
        wait_done();
        cmp("s2_umin_result", 64'(result), 64'h1);
        cmp("s2_umin_idx", 64'(result_idx), 64'd0);

        // 3: zero length answers one cycle after start, never ready
        do_start(0, 1, 1);
        cmp("s3_done", 64'(done), 64'd1);
        cmp("s3_empty", 64'(empty), 64'd1);
        cmp("s3_result", 64'(result), 64'd0);
        cmp("s3_ready", 64'(in_ready), 64'd0);
        @(negedge clk);

        // 4: len clamped to MAX_LEN, value = index
        do_start(31, 1, 0);
        acc = 0; late_nr = 0;
        for (int i = 0; i < 20; i++) begin
            in_valid = 1'b1; in_data = W'(i);
            if (in_ready) acc++;
            else if (i >= 16) late_nr++;
            @(negedge clk);
        end
        in_valid = 1'b0;
        cmp("s4_accepted", 64'(acc), 64'd16);
        cmp("s4_late_not_ready", 64'(late_nr), 64'd4);
        wait_done();
        cmp("s4_result", 64'(result), 64'd15);
        cmp("s4_idx", 64'(result_idx), 64'd15);

        // 5: reset mid-operation, then a one-element operation
        do_start(4, 1, 0);
        send_beat(32'd3, 0, 0);
        send_beat(32'd8, 0, 0);
        reset = 1'b0;
        @(negedge clk);
        cmp("s5_done", 64'(done), 64'd0);
        cmp("s5_result", 64'(result), 64'd0);
        cmp("s5_ready", 64'(in_ready), 64'd0);
        reset = 1'b1;
        @(negedge clk);
        do_start(1, 1, 0);
        send_beat(32'd7, 0, 0);
        wait_done();
        cmp("s5_result7", 64'(result), 64'd7);
        cmp("s5_idx", 64'(result_idx), 64'd0);

        // 6: scenario 1 again with start/len/mode poked while busy
        do_start(4, 1, 0);
        for (int i = 0; i < 4; i++) send_beat(s1[i], 0, (i == 1 || i == 2));
        wait_done();
        cmp("s6_result", 64'(result), 64'd9);
        cmp("s6_idx", 64'(result_idx), 64'd1);

        // Randomized operations: extremes, ties, gaps, mid-operation pokes
        for (int op = 0; op < 40; op++) begin
            l = $urandom_range(0, 20);
            do_start(l, 1'($urandom), 1'($urandom));
            if (l == 0) begin
                @(negedge clk);
                continue;
            end
            n = (l > MAXL) ? MAXL : l;
            for (int b = 0; b < n; b++) begin
                sel = $urandom_range(0, 3);
                case (sel)
                    0: d = $urandom;
                    1: d = W'($urandom_range(0, 3));
                    2: d = 32'h80000000 | W'($urandom_range(0, 1));
                    default: d = 32'h7FFFFFFF - W'($urandom_range(0, 1));
                endcase
                send_beat(d, $urandom_range(0, 2), ($urandom_range(0, 4) == 0));
            end
            wait_done();
            repeat ($urandom_range(0, 2)) @(negedge clk);
        end

        @(negedge clk);
        chk_en = 1'b0;
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
